display_value_formatter: RTL

Upstream feeder of the four-digit seven-segment scanner. Accepts a 16-bit value written by the CPU's display I/O port and produces the 16-bit packed-nibble word the scanner shows, one nibble per digit (bits [3:0] = rightmost digit). Hex mode passes the value through unchanged. Decimal mode converts to four packed BCD digits with a sequential shift-and-add-3 (double-dabble) engine, saturating at 9999. The output holds its previous value until a conversion completes, so the display never shows partial results.

---
 rtl/display_value_formatter_pkg.sv | 7 +
 rtl/display_value_formatter_bcd_add3.sv | 10 +
 rtl/display_value_formatter.sv | 96 +++++++++
 3 files changed

// File: rtl/display_value_formatter_pkg.sv
// display_value_formatter_pkg: shared state type and constants for the display value formatter
package display_value_formatter_pkg;
    typedef enum logic {IDLE, CONVERT} state_t;
    localparam logic [15:0] DEC_MAX    = 16'd9999;
    localparam logic [15:0] SAT_BCD    = 16'h9999;
    localparam int          ITER_COUNT = 16;
endpackage

// File: rtl/display_value_formatter_bcd_add3.sv
// bcd_add3: double-dabble nibble correction, d_i (4) -> q_o (4) = d_i+3 when d_i >= 5
module bcd_add3
    import display_value_formatter_pkg::*;
(
    input  logic [3:0] d_i,
    input  logic       unused_i,
    output logic [3:0] q_o
);
    assign q_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
endmodule

// File: rtl/display_value_formatter.sv
// display_value_formatter: 16-bit value -> packed display nibbles (hex pass-through or saturating BCD)
// ports: clk, rst (async, active-high), wr_en/wr_data/mode_dec (CPU write),
//        disp_value/busy/done/overflow/dropped (to scanner and status)
module display_value_formatter
    import display_value_formatter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    input  logic        mode_dec,
    output logic [15:0] disp_value,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic        dropped
);
    state_t      state_q, state_d;
    logic [15:0] bin_q, bin_d, bcd_q, bcd_d, disp_q, disp_d, adj;
    logic [4:0]  cnt_q, cnt_d;
    logic        ovf_q, ovf_d, done_q, done_d, drop_q, drop_d;
    logic [31:0] sh;

    for (genvar i = 0; i < 4; i++) begin : g_add3
        bcd_add3 u_add3 (.d_i(bcd_q[4*i +: 4]), .unused_i(1'b0), .q_o(adj[4*i +: 4]));
    end

    // one double-dabble step: adjusted BCD and remaining binary shift left together
    assign sh = {adj, bin_q} << 1;

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        drop_d  = 1'b0;
        if (state_q == IDLE) begin
            if (wr_en && !mode_dec) begin
                disp_d = wr_data;
                ovf_d  = 1'b0;
                done_d = 1'b1;
            end else if (wr_en && wr_data > DEC_MAX) begin
                disp_d = SAT_BCD;
                ovf_d  = 1'b1;
                done_d = 1'b1;
            end else if (wr_en) begin
                bin_d   = wr_data;
                bcd_d   = '0;
                cnt_d   = '0;
                state_d = CONVERT;
            end
        end else begin
            bcd_d  = sh[31:16];
            bin_d  = sh[15:0];
            cnt_d  = cnt_q + 5'd1;
            drop_d = wr_en;
            if (cnt_q == 5'(ITER_COUNT - 1)) begin
                disp_d  = sh[31:16];
                ovf_d   = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
        end
    end

    assign disp_value = disp_q;
    assign busy       = (state_q == CONVERT);
    assign done       = done_q;
    assign overflow   = ovf_q;
    assign dropped    = drop_q;
endmodule
